line_shift_window: RTL and testbench



---
 rtl/line_shift_window.sv | 136 +++++++++++++
 tb/tb_line_shift_window.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/line_shift_window.sv
// Streaming KxK x CH window generator over raster-order, channel-interleaved pixels.
// Optional LINE_SHIFT_STRIDE2_EN: emit only windows at even row/column offsets.
module line_shift_window #(
    parameter int DATA_W = 8,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CH     = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  logic                         in_sof,
    input  logic [DATA_W-1:0]            in_data,
    output logic                         win_valid,
    output logic [K*K*CH*DATA_W-1:0]     win_data,
    output logic                         frame_done
);

    localparam int LINE_LEN = IMG_W * CH;
    localparam int MEM_LEN  = (K - 1) * LINE_LEN;
    localparam int CW       = (CH > 1) ? $clog2(CH) : 1;
    localparam int XW       = $clog2(IMG_W);
    localparam int YW       = $clog2(IMG_H);

    localparam logic [CW-1:0] CH_LAST   = CW'(CH - 1);
    localparam logic [XW-1:0] COL_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] ROW_LAST  = YW'(IMG_H - 1);
    localparam logic [XW-1:0] COL_FIRST = XW'(K - 1);
    localparam logic [YW-1:0] ROW_FIRST = YW'(K - 1);

    logic [CW-1:0]   ch_cnt,  ch_cur;
    logic [XW-1:0]   col_cnt, col_cur;
    logic [YW-1:0]   row_cnt, row_cur;
    logic            stride_ok, trig_p0, last_p0;

    logic [DATA_W-1:0] line_mem [MEM_LEN];
    logic [DATA_W-1:0] win_reg  [K][K][CH];
    logic [DATA_W-1:0] win_nxt  [K][K][CH];
    logic [DATA_W-1:0] slice    [K];
    logic [K*K*CH*DATA_W-1:0] win_flat;

    // A qualified sof restarts the position at (0,0,0) for this very sample.
    always_comb begin
        ch_cur  = in_sof ? '0 : ch_cnt;
        col_cur = in_sof ? '0 : col_cnt;
        row_cur = in_sof ? '0 : row_cnt;
    end

`ifdef LINE_SHIFT_STRIDE2_EN
    assign stride_ok = (row_cur[0] == ROW_FIRST[0]) && (col_cur[0] == COL_FIRST[0]);
`else
    assign stride_ok = 1'b1;
`endif

    assign trig_p0 = (ch_cur == CH_LAST) && (row_cur >= ROW_FIRST) &&
                     (col_cur >= COL_FIRST) && stride_ok;
    assign last_p0 = !in_sof && (ch_cnt == CH_LAST) && (col_cnt == COL_LAST) &&
                     (row_cnt == ROW_LAST);

    // Vertical slice: tap j lines back sits at the end of the j-th line segment.
    always_comb begin
        for (int r = 0; r < K - 1; r++) begin
            slice[r] = line_mem[(K - 1 - r) * LINE_LEN - 1];
        end
        slice[K-1] = in_data;
    end

    always_comb begin
        win_nxt  = win_reg;
        win_flat = '0;
        for (int ch = 0; ch < CH; ch++) begin
            if (CW'(ch) == ch_cur) begin
                for (int r = 0; r < K; r++) begin
                    for (int c = 0; c < K - 1; c++) begin
                        win_nxt[r][c][ch] = win_reg[r][c+1][ch];
                    end
                    win_nxt[r][K-1][ch] = slice[r];
                end
            end
        end
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                for (int ch = 0; ch < CH; ch++) begin
                    win_flat[((r*K + c)*CH + ch)*DATA_W +: DATA_W] = win_nxt[r][c][ch];
                end
            end
        end
    end

    // Stage p0 -> p1: position counters and registered window outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_cnt     <= '0;
            col_cnt    <= '0;
            row_cnt    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            win_data   <= '0;
        end else begin
            win_valid  <= in_valid && trig_p0;
            frame_done <= in_valid && last_p0;
            if (in_valid) begin
                if (trig_p0) begin
                    win_data <= win_flat;
                end
                if (ch_cur == CH_LAST) begin
                    ch_cnt <= '0;
                    if (col_cur == COL_LAST) begin
                        col_cnt <= '0;
                        row_cnt <= (row_cur == ROW_LAST) ? '0 : row_cur + YW'(1);
                    end else begin
                        col_cnt <= col_cur + XW'(1);
                        row_cnt <= row_cur;
                    end
                end else begin
                    ch_cnt  <= ch_cur + CW'(1);
                    col_cnt <= col_cur;
                    row_cnt <= row_cur;
                end
            end
        end
    end

    // Line and window storage are deliberately never cleared.
    always_ff @(posedge clk) begin
        if (in_valid && !rst) begin
            line_mem[0] <= in_data;
            for (int i = 1; i < MEM_LEN; i++) begin
                line_mem[i] <= line_mem[i-1];
            end
            win_reg <= win_nxt;
        end
    end

endmodule

// File: tb/tb_line_shift_window.sv
// Bench for line_shift_window: CH=1 and CH=3 instances share one input stream and
// are compared every cycle against a frame-array reference model.
module tb_line_shift_window;

    localparam int W = 8;
    localparam int H = 8;
    localparam int KK = 3;
`ifdef LINE_SHIFT_STRIDE2_EN
    localparam int EXP_WIN = 9;
`else
    localparam int EXP_WIN = 36;
`endif

    logic         clk = 1'b0;
    logic         rst, in_valid, in_sof;
    logic [7:0]   in_data;
    logic         wv1, fd1, wv3, fd3;
    logic [71:0]  wd1;
    logic [215:0] wd3;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    line_shift_window #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(KK), .CH(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .win_valid(wv1), .win_data(wd1), .frame_done(fd1));

    line_shift_window #(.DATA_W(8), .IMG_W(W), .IMG_H(H), .K(KK), .CH(3)) dut3 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
        .win_valid(wv3), .win_data(wd3), .frame_done(fd3));

    // Reference model state: the current frame as a flat sample array per instance.
    logic [7:0]   mem0 [64];
    logic [7:0]   mem1 [192];
    int           pos  [2];
    logic [215:0] hold [2];
    logic         ewv  [2];
    logic         efd  [2];

    // Statistics of the latest directed run.
    int           idx_cur;
    int           p1, fd1n, first1, p3, fd3n, first3;
    logic [71:0]  wf1;
    logic [215:0] wf3;
    logic [7:0]   br1 [$];

    task automatic chk(input string tag, input logic [215:0] obs, input logic [215:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model(input int id, input bit rv, input bit v, input bit s, input logic [7:0] d);
        int nch, n, row, col, ch, idx;
        bit trig;
        logic [215:0] w;
        nch = (id == 0) ? 1 : 3;
        n = H * W * nch;
        ewv[id] = 1'b0;
        efd[id] = 1'b0;
        if (rv) begin
            pos[id] = 0;
            hold[id] = '0;
        end else if (v) begin
            if (s) pos[id] = 0;
            if (id == 0) mem0[pos[id]] = d; else mem1[pos[id]] = d;
            row = pos[id] / (W * nch);
            col = (pos[id] / nch) % W;
            ch  = pos[id] % nch;
            trig = (ch == nch - 1) && (row >= KK - 1) && (col >= KK - 1);
`ifdef LINE_SHIFT_STRIDE2_EN
            trig = trig && ((row - KK + 1) % 2 == 0) && ((col - KK + 1) % 2 == 0);
`endif
            if (trig) begin
                w = '0;
                for (int r = 0; r < KK; r++)
                    for (int c = 0; c < KK; c++)
                        for (int cc = 0; cc < nch; cc++) begin
                            idx = ((row - KK + 1 + r) * W + (col - KK + 1 + c)) * nch + cc;
                            w[((r*KK + c)*nch + cc)*8 +: 8] = (id == 0) ? mem0[idx] : mem1[idx];
                        end
                hold[id] = w;
                ewv[id] = 1'b1;
            end
            efd[id] = (pos[id] == n - 1);
            pos[id] = (pos[id] + 1) % n;
        end
    endtask

    task automatic cyc(input bit rv, input bit v, input bit s, input logic [7:0] d);
        rst = rv; in_valid = v; in_sof = s; in_data = d;
        model(0, rv, v, s, d);
        model(1, rv, v, s, d);
        @(negedge clk);
        chk("win_valid_ch1", 216'(wv1), 216'(ewv[0]));
        chk("frame_done_ch1", 216'(fd1), 216'(efd[0]));
        chk("win_data_ch1", 216'(wd1), hold[0]);
        chk("win_valid_ch3", 216'(wv3), 216'(ewv[1]));
        chk("frame_done_ch3", 216'(fd3), 216'(efd[1]));
        chk("win_data_ch3", wd3, hold[1]);
        if (wv1 === 1'b1) begin
            if (p1 == 0) begin first1 = idx_cur; wf1 = wd1; end
            br1.push_back(wd1[71:64]);
            p1++;
        end
        if (fd1 === 1'b1) begin
            fd1n++;
`ifndef LINE_SHIFT_STRIDE2_EN
            chk("frame_done_with_last_window", 216'(wv1), 216'(1));
`endif
        end
        if (wv3 === 1'b1) begin
            if (p3 == 0) begin first3 = idx_cur; wf3 = wd3; end
            p3++;
        end
        if (fd3 === 1'b1) fd3n++;
    endtask

    task automatic reset_stats();
        p1 = 0; fd1n = 0; first1 = -1; p3 = 0; fd3n = 0; first3 = -1;
        wf1 = '0; wf3 = '0;
        br1.delete();
    endtask

    task automatic run_ramp(input int n, input int maxgap);
        for (int i = 0; i < n; i++) begin
            idx_cur = i;
            cyc(1'b0, 1'b1, (i == 0), 8'(i));
            repeat ($urandom_range(0, maxgap)) cyc(1'b0, 1'b0, 1'($urandom), 8'($urandom));
        end
    endtask

    task automatic check_first_ch1(input string tag);
        chk({tag, "_first_idx"}, 216'(first1), 216'(18));
        chk({tag, "_first_win"}, 216'(wf1),
            216'({8'd18, 8'd17, 8'd16, 8'd10, 8'd9, 8'd8, 8'd2, 8'd1, 8'd0}));
        chk({tag, "_win_count"}, 216'(p1), 216'(EXP_WIN));
        chk({tag, "_frame_done_count"}, 216'(fd1n), 216'(1));
    endtask

    initial begin
        int br_exp [9] = '{18, 20, 22, 34, 36, 38, 50, 52, 54};
        reset_stats();
        idx_cur = 0;
        cyc(1'b1, 1'b0, 1'b0, 8'h00);
        cyc(1'b1, 1'b1, 1'b1, 8'h55);
        chk("reset_win_valid", 216'(wv1), 216'(0));
        chk("reset_win_data", 216'(wd3), 216'(0));

        // Continuous 8x8 ramp.
        reset_stats();
        run_ramp(64, 0);
        check_first_ch1("ramp");
`ifdef LINE_SHIFT_STRIDE2_EN
        chk("stride_br_count", 216'(br1.size()), 216'(9));
        for (int j = 0; j < 9 && j < br1.size(); j++)
            chk("stride_bottom_right", 216'(br1[j]), 216'(br_exp[j]));
`else
        chk("stride1_br_second", 216'(br1[1]), 216'(19));
`endif

        // Same ramp with random idle gaps.
        reset_stats();
        run_ramp(64, 3);
        check_first_ch1("gaps");

        // CH=3 ramp: 192 samples.
        reset_stats();
        run_ramp(192, 0);
        chk("ch3_first_idx", 216'(first3), 216'(56));
        chk("ch3_elem000", 216'(wf3[7:0]), 216'(0));
        chk("ch3_elem001", 216'(wf3[15:8]), 216'(1));
        chk("ch3_elem002", 216'(wf3[23:16]), 216'(2));
        chk("ch3_elem222", 216'(wf3[215:208]), 216'(56));
        chk("ch3_win_count", 216'(p3), 216'(EXP_WIN));
        chk("ch3_frame_done_count", 216'(fd3n), 216'(1));

        // sof mid-frame at sample 30.
        reset_stats();
        run_ramp(30, 0);
        reset_stats();
        run_ramp(64, 0);
        check_first_ch1("sof_restart");

        // Reset collides with sample 18.
        reset_stats();
        run_ramp(18, 0);
        idx_cur = 18;
        cyc(1'b1, 1'b1, 1'b0, 8'd18);
        chk("rst_no_window", 216'(p1), 216'(0));
        chk("rst_outputs_zero", {wd1, 1'b0, wv1, fd1}, 216'(0));
        cyc(1'b0, 1'b0, 1'b0, 8'h00);
        reset_stats();
        run_ramp(64, 0);
        check_first_ch1("after_rst");

        // Random data, gaps, stray sof and occasional reset.
        for (int i = 0; i < 1500; i++) begin
            cyc(($urandom % 400) == 0, ($urandom % 4) != 0, ($urandom % 97) == 0, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
